// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
// Shares one data memory between the pipeline MEM stage (CPU port) and a
// secondary bus master (DMA port). The CPU has fixed priority. A streak counter
// forces one DMA slot after MAX_CPU_STREAK consecutive contended CPU grants.
// Grants are combinational from the requests and the registered priority state.
// Read data comes back one cycle after the grant, tagged to the owning port.
//
// Ports
//   CLK, RST_N                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request fields
//   cpu_gnt, cpu_stall         CPU grant this cycle, CPU request denied
//   cpu_rvalid, cpu_rdata      CPU read response (rdata qualified by rvalid)
//   dma_req/we/addr/wdata      DMA request fields
//   dma_gnt                    DMA grant this cycle
//   dma_rvalid, dma_rdata      DMA read response (rdata qualified by rvalid)
//   mem_addr, mem_wdata        to the data memory
//   MemRd, MemWr               memory read / write strobes
//   mem_rdata                  memory data, valid in the cycle after MemRd
//   conflict_cnt               saturating count of cycles with both requests high
module dmem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MemRd,
  output logic              MemWr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam int STREAK_W = $clog2(MAX_CPU_STREAK + 1);
  // The grant that makes the streak reach MAX_CPU_STREAK is taken from this value.
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(MAX_CPU_STREAK - 1);
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);

  typedef enum logic {
    CPU_PRI = 1'b0,
    DMA_PRI = 1'b1
  } pri_e;

  pri_e                state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_own_q, rd_own_d;   // 1'b1 = DMA owns the pending read
  logic [15:0]         conflict_q, conflict_d;

  // Grant decode from the requests and the current priority.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (state_q)
      CPU_PRI: begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
      DMA_PRI: begin
        dma_gnt = dma_req;
        cpu_gnt = cpu_req & ~dma_req;
      end
      default: begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Priority next-state and streak update.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      CPU_PRI: begin
        if (cpu_gnt & dma_req) begin
          if (streak_q == STREAK_LAST) begin
            state_d  = DMA_PRI;
            streak_d = {STREAK_W{1'b0}};
          end else begin
            streak_d = streak_q + STREAK_ONE;
          end
        end else begin
          // DMA idle or DMA served: the waiting streak is over.
          streak_d = {STREAK_W{1'b0}};
        end
      end
      DMA_PRI: begin
        streak_d = {STREAK_W{1'b0}};
        if (dma_gnt | ~dma_req) begin
          state_d = CPU_PRI;
        end else begin
          state_d = DMA_PRI;
        end
      end
      default: begin
        state_d  = CPU_PRI;
        streak_d = {STREAK_W{1'b0}};
      end
    endcase
  end

  // Memory port mux, read tracking and conflict counter next values.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    MemRd     = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    MemWr     = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    rd_pend_d = MemRd;
    rd_own_d  = dma_gnt;
    if (cpu_req & dma_req & (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= CPU_PRI;
      streak_q   <= {STREAK_W{1'b0}};
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
      conflict_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_q   <= rd_own_d;
      conflict_q <= conflict_d;
    end
  end

  assign cpu_rvalid   = rd_pend_q & ~rd_own_q;
  assign dma_rvalid   = rd_pend_q & rd_own_q;
  assign cpu_rdata    = mem_rdata;
  assign dma_rdata    = mem_rdata;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXS = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, MemRd, MemWr;
  logic [15:0]   conflict_cnt;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_STREAK(MAXS)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MemRd(MemRd), .MemWr(MemWr),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Initial memory contents
  function automatic logic [15:0] preload(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    if (a == 16'h0001) return 16'h1111;
    if (a == 16'h0002) return 16'h2222;
    return a ^ 16'hA5C3;
  endfunction

  // Data memory: writes commit on the negedge, reads registered on the posedge
  logic [DW-1:0] fix_mem [0:65535];
  bit            fix_vld [0:65535];
  always @(negedge CLK) begin
    if (MemWr) begin
      fix_mem[mem_addr] <= mem_wdata;
      fix_vld[mem_addr] <= 1'b1;
    end
  end
  always @(posedge CLK) begin
    if (MemRd) mem_rdata <= fix_vld[mem_addr] ? fix_mem[mem_addr] : preload(mem_addr);
  end

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_conf = 16'd0;
  logic [15:0] model_mem [logic [15:0]];

  function automatic logic [15:0] mread(input logic [15:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return preload(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                     input bit dr, input bit dw, input logic [15:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Advance one cycle; inputs are applied at posedge+2, checked at posedge+4
  task automatic step();
    if (cpu_req && dma_req && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
    @(posedge CLK);
    #2;
  endtask

  typedef struct {
    bit cr, cw, dr, dw;
    bit gc, gd, rd, wr, st;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [15:0] ea, ca, da;
    int          cpu_wins;
    bit          pend_v, pend_dma, c_hold, d_hold, eg_c, eg_d, f;
    logic [15:0] pend_data;
    bit          r_cr, r_cw, r_dr, r_dw;
    logic [15:0] r_ca, r_cd, r_da, r_dd;

    //              cr    cw    dr    dw    gc    gd    rd    wr    st
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    RST_N = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    #2;
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk("rst_conflict", conflict_cnt, 16'h0000);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_memrd", MemRd, 1'b0);
    step();

    // Single-cycle vectors from CPU_PRI, each followed by an idle cycle
    for (int i = 0; i < 8; i++) begin
      ca = 16'h00A0 + i[15:0];
      da = 16'h00B0 + i[15:0];
      drv(tbl[i].cr, tbl[i].cw, ca, 16'hC000 + i[15:0], tbl[i].dr, tbl[i].dw, da, 16'hD000 + i[15:0]);
      #2;
      ea = tbl[i].gd ? da : ca;
      chk("tbl_cpu_gnt", cpu_gnt, tbl[i].gc);
      chk("tbl_dma_gnt", dma_gnt, tbl[i].gd);
      chk("tbl_memrd", MemRd, tbl[i].rd);
      chk("tbl_memwr", MemWr, tbl[i].wr);
      chk("tbl_stall", cpu_stall, tbl[i].st);
      chk("tbl_addr", mem_addr, ea);
      step();
      idle();
      #2;
      chk("tbl_cpu_rvalid", cpu_rvalid, tbl[i].gc & tbl[i].rd);
      chk("tbl_dma_rvalid", dma_rvalid, tbl[i].gd & tbl[i].rd);
      step();
    end

    // CPU read of preloaded 0x0010
    drv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    chk("rd_cpu_gnt", cpu_gnt, 1'b1);
    chk("rd_memrd", MemRd, 1'b1);
    chk("rd_addr", mem_addr, 16'h0010);
    step();
    idle();
    #2;
    chk("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk("rd_dma_rvalid", dma_rvalid, 1'b0);
    step();

    // Continuous contention: CPU x4 then one DMA slot, repeating
    drv(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0031, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("con_cpu_gnt", cpu_gnt, (i % 5) != 4);
      chk("con_dma_gnt", dma_gnt, (i % 5) == 4);
      chk("con_stall", cpu_stall, (i % 5) == 4);
      chk("con_count", conflict_cnt, exp_conf);
      step();
    end
    idle();
    step();

    // DMA write then CPU read of the same address
    drv(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234);
    #2;
    chk("wr_dma_gnt", dma_gnt, 1'b1);
    chk("wr_memwr", MemWr, 1'b1);
    chk("wr_addr", mem_addr, 16'h0020);
    chk("wr_wdata", mem_wdata, 16'h1234);
    step();
    drv(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    chk("raw_cpu_gnt", cpu_gnt, 1'b1);
    step();
    idle();
    #2;
    chk("raw_rvalid", cpu_rvalid, 1'b1);
    chk("raw_rdata", cpu_rdata, 16'h1234);
    step();

    // Alternating CPU / DMA reads, one per cycle
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        if (k % 2 == 0) drv(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        else            drv(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
      end else begin
        idle();
      end
      #2;
      if (k > 0) begin
        chk("alt_cpu_rvalid", cpu_rvalid, ((k - 1) % 2) == 0);
        chk("alt_dma_rvalid", dma_rvalid, ((k - 1) % 2) == 1);
        if (((k - 1) % 2) == 0) chk("alt_cpu_rdata", cpu_rdata, 16'h1111);
        else                    chk("alt_dma_rdata", dma_rdata, 16'h2222);
      end
      step();
    end

    // Reset while a read is pending
    drv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    RST_N = 1'b0;
    exp_conf = 16'd0;
    #1;
    chk("mid_rst_rvalid", cpu_rvalid, 1'b0);
    chk("mid_rst_conflict", conflict_cnt, 16'h0000);
    drv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0011, 16'h0000);
    #1;
    chk("mid_rst_cpu_pri", cpu_gnt, 1'b1);
    chk("mid_rst_dma_gnt", dma_gnt, 1'b0);
    RST_N = 1'b1;
    step();
    idle();
    step();

    // Randomized traffic against a reference model
    cpu_wins = 0; pend_v = 1'b0; pend_dma = 1'b0; pend_data = 16'h0000;
    c_hold = 1'b0; d_hold = 1'b0;
    r_cr = 1'b0; r_cw = 1'b0; r_ca = 16'h0; r_cd = 16'h0;
    r_dr = 1'b0; r_dw = 1'b0; r_da = 16'h0; r_dd = 16'h0;
    for (int n = 0; n < 600; n++) begin
      if (!c_hold) begin
        r_cr = ($urandom_range(0, 99) < 60);
        r_cw = $urandom_range(0, 1) == 1;
        r_ca = 16'h0040 + 16'($urandom_range(0, 15));
        r_cd = 16'($urandom);
      end
      if (!d_hold) begin
        r_dr = ($urandom_range(0, 99) < 55);
        r_dw = $urandom_range(0, 1) == 1;
        r_da = 16'h0040 + 16'($urandom_range(0, 15));
        r_dd = 16'($urandom);
      end
      drv(r_cr, r_cw, r_ca, r_cd, r_dr, r_dw, r_da, r_dd);
      // A DMA kept waiting through MAXS CPU wins gets the next slot
      f    = (cpu_wins >= MAXS);
      eg_d = r_dr && (!r_cr || f);
      eg_c = r_cr && !eg_d;
      #2;
      chk("rnd_cpu_gnt", cpu_gnt, eg_c);
      chk("rnd_dma_gnt", dma_gnt, eg_d);
      chk("rnd_stall", cpu_stall, r_cr && !eg_c);
      chk("rnd_memrd", MemRd, (eg_c && !r_cw) || (eg_d && !r_dw));
      chk("rnd_memwr", MemWr, (eg_c && r_cw) || (eg_d && r_dw));
      chk("rnd_addr", mem_addr, eg_d ? r_da : r_ca);
      chk("rnd_wdata", mem_wdata, eg_d ? r_dd : r_cd);
      chk("rnd_cpu_rvalid", cpu_rvalid, pend_v && !pend_dma);
      chk("rnd_dma_rvalid", dma_rvalid, pend_v && pend_dma);
      if (pend_v && !pend_dma) chk("rnd_cpu_rdata", cpu_rdata, pend_data);
      if (pend_v && pend_dma)  chk("rnd_dma_rdata", dma_rdata, pend_data);
      chk("rnd_conflict", conflict_cnt, exp_conf);
      pend_v   = (eg_c && !r_cw) || (eg_d && !r_dw);
      pend_dma = eg_d;
      if (eg_c) begin
        if (r_cw) model_mem[r_ca] = r_cd;
        else      pend_data = mread(r_ca);
      end
      if (eg_d) begin
        if (r_dw) model_mem[r_da] = r_dd;
        else      pend_data = mread(r_da);
      end
      if (!r_dr || eg_d) cpu_wins = 0;
      else if (eg_c)     cpu_wins++;
      c_hold = r_cr && !eg_c;
      d_hold = r_dr && !eg_d;
      step();
    end
    idle();
    step();

    // Conflict counter saturation
    drv(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1, 1'b0, 16'h0051, 16'h0000);
    while (exp_conf != 16'hFFFE) step();
    #2;
    chk("sat_near", conflict_cnt, 16'hFFFE);
    repeat (3) step();
    chk("sat_top", conflict_cnt, 16'hFFFF);
    repeat (2) step();
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
